// File: rtl/md_pkg.sv
// Shared md_op encodings, FSM states and op-class helpers for the md unit.
// MD_UNIT_MADD_EN adds the MADD/MADDU/MSUB/MSUBU ops to the mult class.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } md_op_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic is_mult_class(input logic [3:0] op);
`ifdef MD_UNIT_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD,
                      OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational product / quotient / remainder / accumulate for md_unit.
// Result is {hi,lo}; div results are {remainder,quotient}.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_zero
);

  logic        sgn;
  logic        div_ovf;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] ea;
  logic [63:0] eb;
  logic [63:0] prod;
  logic [63:0] acc;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    sgn  = is_signed_op(op);
    ea   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    prod = ea * eb;
    acc  = op inside {OP_MSUB, OP_MSUBU}
         ? {hi, lo} - prod
         : {hi, lo} + prod;

    // divide on magnitudes, then restore signs
    mag_a    = (sgn && a[31]) ? -a : a;
    mag_b    = (sgn && b[31]) ? -b : b;
    div_zero = (b == 32'd0);
    div_ovf  = sgn && (a == 32'h8000_0000)
                   && (b == 32'hFFFF_FFFF);
    q_mag    = div_zero ? 32'd0 : mag_a / mag_b;
    r_mag    = div_zero ? 32'd0 : mag_a % mag_b;
    neg_q    = sgn & (a[31] ^ b[31]);
    neg_r    = sgn & a[31];
    quo      = neg_q ? -q_mag : q_mag;
    rem      = neg_r ? -r_mag : r_mag;
    if (div_ovf) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end

    unique case (1'b1)
      is_div_class(op): res = {rem, quo};
      is_acc_op(op):    res = acc;
      default:          res = prod;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: FSM, latency counter, pending regs, HI/LO.
// MD_UNIT_MADD_EN enables MADD/MADDU/MSUB/MSUBU through md_pkg.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  logic [0:0]  state;
  logic [3:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_keep;
  logic [63:0] res;
  logic        div_zero;
  logic        idle;
  logic        go_mul;
  logic        go_div;
  logic        go_mthi;
  logic        go_mtlo;

  md_arith u_arith (
    .op       (md_op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .res      (res),
    .div_zero (div_zero)
  );

  assign idle    = (state == ST_IDLE);
  assign busy    = (state == ST_RUN);
  assign go_mul  = idle & start & ~cancel
                 & is_mult_class(md_op);
  assign go_div  = idle & start & ~cancel
                 & is_div_class(md_op);
  assign go_mthi = idle & ~cancel & (md_op == OP_MTHI);
  assign go_mtlo = idle & ~cancel & (md_op == OP_MTLO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_keep <= 1'b0;
    end else if (idle) begin
      if (go_mul || go_div) begin
        pend_hi   <= res[63:32];
        pend_lo   <= res[31:0];
        pend_keep <= go_div & div_zero;
        count     <= go_div ? 4'(DIV_CYCLES)
                            : 4'(MULT_CYCLES);
        state     <= ST_RUN;
      end else if (go_mthi) begin
        hi <= a;
      end else if (go_mtlo) begin
        lo <= a;
      end
    end else if (count == 4'd1) begin
      // div-by-zero still burns its cycles but leaves HI/LO alone
      if (!pend_keep) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      count <= '0;
      state <= ST_IDLE;
    end else begin
      count <= count - 4'd1;
    end
  end

  always_comb begin
    md_out = '0;
    if (md_op == OP_MFHI)
      md_out = hi;
    else if (md_op == OP_MFLO)
      md_out = lo;
  end

  a_no_issue_while_busy: assert property (
    @(posedge clk) disable iff (!reset_n)
    busy |-> !(start || md_op inside {OP_MTHI, OP_MTLO})
  );

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected HI/LO/latency,
// monitors pop on busy fall and on mfhi/mflo reads.
module tb_md_unit;
  import md_pkg::*;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [3:0]  md_op = OP_NOP;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  md_unit #(.MULT_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .cancel  (cancel),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  typedef struct {
    logic [31:0] val;
    string       tag;
  } rd_t;

  exp_t        exp_q[$];
  rd_t         rd_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
`ifdef MD_UNIT_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // monitor: completion of multi-cycle ops and combinational reads
  initial begin
    bit   prev_busy = 1'b0;
    int   run_len = 0;
    exp_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_busy = 1'b0;
        run_len   = 0;
      end else begin
        if (busy) run_len++;
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            check("spurious_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check({e.tag, "_busy_len"}, run_len, e.len);
            check({e.tag, "_hi"}, hi, e.hi);
            check({e.tag, "_lo"}, lo, e.lo);
          end
          run_len = 0;
        end
        prev_busy = busy;
        if (md_op == OP_MFHI || md_op == OP_MFLO) begin
          if (rd_q.size() == 0) begin
            check("spurious_read", 1, 0);
          end else begin
            r = rd_q.pop_front();
            check({r.tag, "_md_out"}, md_out, r.val);
          end
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op,
                       input logic [31:0] av,
                       input logic [31:0] bv,
                       input logic st,
                       input logic cn);
    @(posedge clk); #1;
    md_op = op; a = av; b = bv; start = st; cancel = cn;
    @(posedge clk); #1;
    md_op = OP_NOP; start = 1'b0; cancel = 1'b0;
  endtask

  // reference: {hi,lo} after the op, from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] av,
                                             input logic [31:0] bv);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] cur;
    bit          sg;
    cur = {m_hi, m_lo};
    sg  = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    sa  = sg ? longint'($signed(av)) : longint'({32'b0, av});
    sb  = sg ? longint'($signed(bv)) : longint'({32'b0, bv});
    p   = sg ? 64'(sa * sb) : {32'b0, av} * {32'b0, bv};
    case (op)
      OP_DIV, OP_DIVU:
        if (bv == 0) return cur;
        else return {32'(sa % sb), 32'(sa / sb)};
      OP_MADD, OP_MADDU: return cur + p;
      OP_MSUB, OP_MSUBU: return cur - p;
      default: return p;
    endcase
  endfunction

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, 1, 0);
      exp_q.delete();
    end
  endtask

  task automatic run_md(input logic [3:0] op,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        input string tag);
    logic [63:0] r;
    exp_t        e;
    bit          acc;
    acc = op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    if (acc && !MADD_ON) begin
      drive(op, av, bv, 1'b1, 1'b0);
      check({tag, "_nobusy"}, busy, 0);
      return;
    end
    r = ref_result(op, av, bv);
    e.len = (op inside {OP_DIV, OP_DIVU}) ? DIV_N : MUL_N;
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.tag = tag;
    exp_q.push_back(e);
    m_hi = r[63:32];
    m_lo = r[31:0];
    drive(op, av, bv, 1'b1, 1'b0);
    wait_done(tag);
  endtask

  task automatic rd(input logic [3:0] op, input string tag);
    rd_t r;
    r.val = (op == OP_MFHI) ? m_hi : m_lo;
    r.tag = tag;
    rd_q.push_back(r);
    drive(op, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic mt(input logic [3:0] op,
                    input logic [31:0] av,
                    input logic cn);
    drive(op, av, 32'd0, 1'b0, cn);
    check("mt_nobusy", busy, 0);
    if (!cn) begin
      if (op == OP_MTHI) m_hi = av;
      else m_lo = av;
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [3:0] ops[4];
    ops[0] = OP_MADD;  ops[1] = OP_MADDU;
    ops[2] = OP_MSUB;  ops[3] = OP_MSUBU;

    #22;
    check("rst_busy", busy, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_md_out", md_out, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_md(OP_MULT,  32'hFFFF_FFFF, 32'd2, "mult_neg1x2");
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
    run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_m7_2");
    mt(OP_MTHI, 32'h11, 1'b0);
    mt(OP_MTLO, 32'h22, 1'b0);
    run_md(OP_DIVU,  32'd7, 32'd0, "divu_by_zero");
    mt(OP_MTHI, 32'h1234, 1'b1);
    rd(OP_MFHI, "mthi_cancel");
    mt(OP_MTHI, 32'h1234, 1'b0);
    rd(OP_MFHI, "mthi");
    rd(OP_MFLO, "mflo");
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

    drive(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b1);
    check("start_cancel_nobusy", busy, 0);
    rd(OP_MFLO, "start_cancel_lo");

    // cancel arriving mid-run must not abort the op
    e.len = MUL_N; e.hi = 32'd0; e.lo = 32'd42;
    e.tag = "cancel_in_run";
    exp_q.push_back(e);
    m_hi = 32'd0; m_lo = 32'd42;
    drive(OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b0);
    drive(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b1);
    wait_done("cancel_in_run");

    mt(OP_MTHI, 32'h0000_0001, 1'b0);
    mt(OP_MTLO, 32'hFFFF_FFFF, 1'b0);
    run_md(OP_MADD,  32'hFFFF_FFFF, 32'd3, "madd");
    run_md(OP_MADDU, 32'hFFFF_FFFF, 32'd3, "maddu");
    run_md(OP_MSUB,  32'd5, 32'hFFFF_FFFE, "msub");
    run_md(OP_MSUBU, 32'h8000_0000, 32'd4, "msubu");
    rd(OP_MFHI, "madd_hi");
    rd(OP_MFLO, "madd_lo");

    // async reset in the third busy cycle of a div
    drive(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    run_md(OP_MULT, 32'd1000, 32'hFFFF_FFFD, "after_rst_mult");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: run_md(OP_MULT,  rnd_opnd(), rnd_opnd(), "r_mult");
        1: run_md(OP_MULTU, rnd_opnd(), rnd_opnd(), "r_multu");
        2: run_md(OP_DIV,   rnd_opnd(), rnd_opnd(), "r_div");
        3: run_md(OP_DIVU,  rnd_opnd(), rnd_opnd(), "r_divu");
        4: mt(OP_MTHI, $urandom, 1'($urandom_range(0, 1)));
        5: mt(OP_MTLO, $urandom, 1'($urandom_range(0, 1)));
        6: rd(OP_MFHI, "r_mfhi");
        7: rd(OP_MFLO, "r_mflo");
        8: run_md(ops[$urandom_range(0, 3)],
                  rnd_opnd(), rnd_opnd(), "r_acc");
        default: begin
          drive(OP_DIV, rnd_opnd(), rnd_opnd(), 1'b1, 1'b1);
          check("r_start_cancel", busy, 0);
        end
      endcase
    end
    rd(OP_MFHI, "final_hi");
    rd(OP_MFLO, "final_lo");

    @(negedge clk);
    check("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
